// File: rtl/dfr_ctrl_pkg.sv
// Shared types and defaults for the DFR batch sequencer slice.
package dfr_ctrl_pkg;

    localparam int unsigned DFR_CNT_W   = 16;
    localparam int unsigned DFR_BATCH_W = 8;

    // Encodings are exposed on current_state_out and must stay fixed.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_RES_STEP = 3'd2,
        ST_RES_WAIT = 3'd3,
        ST_MM_START = 3'd4,
        ST_MM_WAIT  = 3'd5,
        ST_DONE     = 3'd6
    } dfr_state_e;

    function automatic logic is_wait_state(input dfr_state_e s);
        return (s == ST_RES_WAIT) || (s == ST_MM_WAIT);
    endfunction

endpackage

// File: rtl/dfr_batch_sequencer_if.sv
// Control/status bundle between the register file, the datapath and the batch sequencer.
interface dfr_batch_sequencer_if
    import dfr_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = DFR_CNT_W,
    parameter int unsigned BATCH_W = DFR_BATCH_W
);

    logic               start;
    logic               abort;
    logic [CNT_W-1:0]   cfg_init_len;
    logic [CNT_W-1:0]   cfg_num_samples;
    logic [BATCH_W-1:0] cfg_num_batches;
    logic               reservoir_valid;
    logic               matrix_multiply_busy;

    logic               busy;
    logic               done;
    logic               aborted;
    logic               error;
    logic               reservoir_rst;
    logic               reservoir_en;
    logic               reservoir_history_rst;
    logic               reservoir_history_en;
    logic               matrix_multiply_rst;
    logic               matrix_multiply_start;
    logic [CNT_W-1:0]   sample_idx;
    logic [BATCH_W-1:0] batch_idx;
    logic [2:0]         current_state_out;

    modport master (
        output start, abort, cfg_init_len, cfg_num_samples, cfg_num_batches,
               reservoir_valid, matrix_multiply_busy,
        input  busy, done, aborted, error, reservoir_rst, reservoir_en,
               reservoir_history_rst, reservoir_history_en, matrix_multiply_rst,
               matrix_multiply_start, sample_idx, batch_idx, current_state_out
    );

    modport slave (
        input  start, abort, cfg_init_len, cfg_num_samples, cfg_num_batches,
               reservoir_valid, matrix_multiply_busy,
        output busy, done, aborted, error, reservoir_rst, reservoir_en,
               reservoir_history_rst, reservoir_history_en, matrix_multiply_rst,
               matrix_multiply_start, sample_idx, batch_idx, current_state_out
    );

endinterface

// File: rtl/dfr_wait_watchdog.sv
// Cycle counter bounding how long the sequencer may sit in a wait state.
module dfr_wait_watchdog #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q;

    // Expiry fires on the TIMEOUT-th enabled cycle, so the counter never exceeds TIMEOUT-1.
    assign expired_o = enable_i && (cnt_q == W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/dfr_batch_sequencer.sv
// DFR batch sequencer: reservoir reset, N reservoir steps, one matrix multiply, repeated per batch.
// Optional wait watchdog enabled by defining DFR_WATCHDOG_EN.
module dfr_batch_sequencer
    import dfr_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = DFR_CNT_W,
    parameter int unsigned BATCH_W = DFR_BATCH_W,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dfr_batch_sequencer_if.slave  bus
);

    dfr_state_e         state_q;
    logic [CNT_W-1:0]   init_len_q;
    logic [CNT_W-1:0]   num_samples_q;
    logic [BATCH_W-1:0] num_batches_q;
    logic [CNT_W-1:0]   sample_idx_q;
    logic [BATCH_W-1:0] batch_idx_q;
    logic               mm_guard_q;

    logic busy_q, done_q, aborted_q, error_q;
    logic res_rst_q, res_en_q, hist_rst_q, hist_en_q, mm_rst_q, mm_start_q;

    logic [CNT_W-1:0]   sample_nxt;
    logic [BATCH_W-1:0] batch_nxt;
    logic               wd_expired;

    assign sample_nxt = sample_idx_q + 1'b1;
    assign batch_nxt  = batch_idx_q + 1'b1;

`ifdef DFR_WATCHDOG_EN
    logic wd_clear;
    logic wd_enable;

    assign wd_clear  = (state_q == ST_RES_STEP) || (state_q == ST_MM_START);
    assign wd_enable = is_wait_state(state_q);

    dfr_wait_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );
`else
    logic unused_timeout;

    assign wd_expired     = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    // Pulses are raised on entry to a state so each one is aligned with that state's cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            init_len_q    <= '0;
            num_samples_q <= '0;
            num_batches_q <= '0;
            sample_idx_q  <= '0;
            batch_idx_q   <= '0;
            mm_guard_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            error_q       <= 1'b0;
            res_rst_q     <= 1'b0;
            res_en_q      <= 1'b0;
            hist_rst_q    <= 1'b0;
            hist_en_q     <= 1'b0;
            mm_rst_q      <= 1'b0;
            mm_start_q    <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            res_rst_q  <= 1'b0;
            res_en_q   <= 1'b0;
            hist_rst_q <= 1'b0;
            hist_en_q  <= 1'b0;
            mm_rst_q   <= 1'b0;
            mm_start_q <= 1'b0;

            if ((state_q != ST_IDLE) && bus.abort) begin
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
                aborted_q <= 1'b1;
                res_rst_q <= 1'b1;
                mm_rst_q  <= 1'b1;
            end else if (wd_expired) begin
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
                error_q   <= 1'b1;
                res_rst_q <= 1'b1;
                mm_rst_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            init_len_q    <= bus.cfg_init_len;
                            num_samples_q <= bus.cfg_num_samples;
                            num_batches_q <= bus.cfg_num_batches;
                            batch_idx_q   <= '0;
                            error_q       <= 1'b0;
                            busy_q        <= 1'b1;
                            if ((bus.cfg_num_samples == '0) || (bus.cfg_num_batches == '0)) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q      <= ST_SETUP;
                                res_rst_q    <= 1'b1;
                                hist_rst_q   <= 1'b1;
                                mm_rst_q     <= 1'b1;
                                sample_idx_q <= '0;
                            end
                        end
                    end
                    ST_SETUP: begin
                        state_q  <= ST_RES_STEP;
                        res_en_q <= 1'b1;
                    end
                    ST_RES_STEP: begin
                        state_q <= ST_RES_WAIT;
                    end
                    ST_RES_WAIT: begin
                        if (bus.reservoir_valid) begin
                            hist_en_q    <= (sample_idx_q >= init_len_q);
                            sample_idx_q <= sample_nxt;
                            if (sample_nxt == num_samples_q) begin
                                state_q    <= ST_MM_START;
                                mm_start_q <= 1'b1;
                            end else begin
                                state_q  <= ST_RES_STEP;
                                res_en_q <= 1'b1;
                            end
                        end
                    end
                    ST_MM_START: begin
                        state_q    <= ST_MM_WAIT;
                        mm_guard_q <= 1'b1;
                    end
                    ST_MM_WAIT: begin
                        // First cycle is skipped: the multiplier may not have raised busy yet.
                        if (mm_guard_q) begin
                            mm_guard_q <= 1'b0;
                        end else if (!bus.matrix_multiply_busy) begin
                            batch_idx_q <= batch_nxt;
                            if (batch_nxt < num_batches_q) begin
                                state_q      <= ST_SETUP;
                                res_rst_q    <= 1'b1;
                                hist_rst_q   <= 1'b1;
                                mm_rst_q     <= 1'b1;
                                sample_idx_q <= '0;
                            end else begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy                  = busy_q;
    assign bus.done                  = done_q;
    assign bus.aborted               = aborted_q;
    assign bus.error                 = error_q;
    assign bus.reservoir_rst         = res_rst_q;
    assign bus.reservoir_en          = res_en_q;
    assign bus.reservoir_history_rst = hist_rst_q;
    assign bus.reservoir_history_en  = hist_en_q;
    assign bus.matrix_multiply_rst   = mm_rst_q;
    assign bus.matrix_multiply_start = mm_start_q;
    assign bus.sample_idx            = sample_idx_q;
    assign bus.batch_idx             = batch_idx_q;
    assign bus.current_state_out     = state_q;

endmodule

// File: tb/tb_dfr_batch_sequencer.sv
// Self-checking bench for dfr_batch_sequencer: event-count model plus directed corner cases.
module tb_dfr_batch_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dfr_batch_sequencer_if #(.CNT_W(16), .BATCH_W(8)) bus ();

    dfr_batch_sequencer #(
        .CNT_W   (16),
        .BATCH_W (8),
        .TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int n_en, n_hist, n_mm, n_rrst, n_hrst, n_mrst, n_done, n_abort, max_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start                = 1'b0;
        bus.abort                = 1'b0;
        bus.reservoir_valid      = 1'b0;
        bus.matrix_multiply_busy = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({bus.busy, bus.done, bus.aborted, bus.error, bus.reservoir_rst,
                      bus.reservoir_en, bus.reservoir_history_rst, bus.reservoir_history_en,
                      bus.matrix_multiply_rst, bus.matrix_multiply_start, bus.sample_idx,
                      bus.batch_idx, bus.current_state_out}), 64'd0);
    endtask

    // mode 0: normal run; mode 1: abort together with the valid of sample abort_at;
    // mode 2: assert reset on the first MM_WAIT cycle.
    task automatic run(input int init, input int samples, input int batches,
                       input int mode, input int abort_at);
        int  cyc, vwait, bcount, eff, exp_hist, exp_b;
        bit  fin, saw_en, saw_mm;
        n_en = 0; n_hist = 0; n_mm = 0; n_rrst = 0; n_hrst = 0; n_mrst = 0;
        n_done = 0; n_abort = 0; max_b = 0;
        cyc = 0; vwait = 0; bcount = 0; fin = 1'b0;
        eff   = (samples > 0 && batches > 0) ? 1 : 0;
        exp_b = eff * batches;
        bus.cfg_init_len    = 16'(init);
        bus.cfg_num_samples = 16'(samples);
        bus.cfg_num_batches = 8'(batches);
        bus.start           = 1'b1;
        while (!fin && cyc < 3000) begin
            tick();
            cyc++;
            saw_en = bus.reservoir_en;
            saw_mm = bus.matrix_multiply_start;
            if (saw_en) n_en++;
            if (saw_mm) n_mm++;
            if (bus.reservoir_rst) n_rrst++;
            if (bus.reservoir_history_rst) n_hrst++;
            if (bus.matrix_multiply_rst) n_mrst++;
            if (bus.reservoir_history_en) begin
                n_hist++;
                chk("hist_after_warmup", 64'(int'(bus.sample_idx) > init), 64'd1);
            end
            if (int'(bus.batch_idx) > max_b) max_b = int'(bus.batch_idx);
            if (bus.done) begin
                n_done++;
                fin = 1'b1;
                chk("done_state", 64'(bus.current_state_out), 64'd6);
                chk("done_busy", 64'(bus.busy), 64'd1);
                chk("done_batch_idx", 64'(bus.batch_idx), 64'(exp_b));
            end
            if (bus.aborted) begin
                n_abort++;
                fin = 1'b1;
                chk("abort_state", 64'(bus.current_state_out), 64'd0);
                chk("abort_busy", 64'(bus.busy), 64'd0);
                chk("abort_rst_pulses", 64'({bus.reservoir_rst, bus.matrix_multiply_rst}), 64'd3);
                chk("abort_no_hist", 64'(bus.reservoir_history_en), 64'd0);
            end
            if (mode == 2 && !fin && bus.current_state_out == 3'd5) begin
                rst_n = 1'b0;
                tick();
                chk_all_zero("reset_in_mm_wait");
                rst_n = 1'b1;
                fin   = 1'b1;
            end
            if (!fin) begin
                bus.reservoir_valid = 1'b0;
                bus.abort           = 1'b0;
                if (vwait > 0) begin
                    vwait--;
                    if (vwait == 0) begin
                        bus.reservoir_valid = 1'b1;
                        if (mode == 1 && int'(bus.sample_idx) == abort_at) bus.abort = 1'b1;
                    end
                end
                if (saw_en) vwait = $urandom_range(1, 4);
                bus.matrix_multiply_busy = (bcount > 0);
                if (bcount > 0) bcount--;
                if (saw_mm) bcount = $urandom_range(0, 4);
                // Mid-run config churn and stray starts must not disturb the latched run.
                bus.cfg_init_len    = 16'($urandom);
                bus.cfg_num_samples = 16'($urandom);
                bus.cfg_num_batches = 8'($urandom);
                bus.start           = 1'($urandom_range(0, 1));
            end
        end
        clear_inputs();
        chk("run_terminated", 64'(fin), 64'd1);
        if (mode == 0) begin
            exp_hist = (samples > init) ? (samples - init) * batches * eff : 0;
            chk("cnt_reservoir_en", 64'(n_en), 64'(samples * batches * eff));
            chk("cnt_history_en", 64'(n_hist), 64'(exp_hist));
            chk("cnt_mm_start", 64'(n_mm), 64'(exp_b));
            chk("cnt_setup_rst", 64'({n_rrst[15:0], n_hrst[15:0], n_mrst[15:0]}),
                64'({16'(exp_b), 16'(exp_b), 16'(exp_b)}));
            chk("cnt_done", 64'(n_done), 64'd1);
            chk("max_batch_idx", 64'(max_b), 64'(exp_b));
            tick();
            chk("after_done_idle", 64'({bus.busy, bus.done, bus.current_state_out}), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        bus.cfg_init_len    = '0;
        bus.cfg_num_samples = '0;
        bus.cfg_num_batches = '0;
        repeat (3) tick();
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        tick();

        bus.abort = 1'b1;
        tick();
        chk("abort_in_idle", 64'({bus.aborted, bus.busy, bus.current_state_out}), 64'd0);
        bus.abort = 1'b0;

        run(2, 5, 1, 0, 0);
        run(0, 4, 3, 0, 0);
        run(1, 0, 2, 0, 0);
        run(0, 3, 0, 0, 0);
        run(6, 4, 2, 0, 0);
        run(4, 4, 1, 0, 0);

        run(0, 6, 1, 1, 2);
        chk("abort_cnt_en", 64'(n_en), 64'd3);
        chk("abort_cnt_hist", 64'(n_hist), 64'd2);
        chk("abort_no_done", 64'({n_done[7:0], n_mm[7:0]}), 64'd0);
        chk("abort_cnt_rrst", 64'(n_rrst), 64'd2);
        chk("abort_pulse_once", 64'(n_abort), 64'd1);
        tick();
        chk("abort_pulse_cleared", 64'(bus.aborted), 64'd0);

        run(1, 3, 2, 2, 0);
        tick();
        chk_all_zero("post_reset_quiet");
        run(1, 3, 2, 0, 0);

        for (int r = 0; r < 8; r++) begin
            run(int'($urandom_range(0, 5)), int'($urandom_range(1, 6)),
                int'($urandom_range(1, 3)), 0, 0);
        end

        // Reservoir never answers.
        bus.cfg_init_len    = 16'd0;
        bus.cfg_num_samples = 16'd3;
        bus.cfg_num_batches = 8'd1;
        bus.start           = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("stall_setup", 64'(bus.current_state_out), 64'd1);
        tick();
        chk("stall_res_step", 64'({bus.reservoir_en, bus.current_state_out}), 64'({1'b1, 3'd2}));
        tick();
        chk("stall_res_wait", 64'(bus.current_state_out), 64'd3);
`ifdef DFR_WATCHDOG_EN
        repeat (15) tick();
        chk("wd_before_limit", 64'({bus.error, bus.current_state_out}), 64'({1'b0, 3'd3}));
        tick();
        chk("wd_expired", 64'({bus.error, bus.reservoir_rst, bus.matrix_multiply_rst,
                               bus.done, bus.current_state_out}), 64'({4'b1110, 3'd0}));
        tick();
        chk("wd_error_sticky", 64'(bus.error), 64'd1);
        bus.cfg_num_samples = 16'd0;
        bus.start           = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("wd_start_clears", 64'({bus.error, bus.current_state_out}), 64'({1'b0, 3'd6}));
        tick();
`else
        repeat (40) tick();
        chk("stall_no_watchdog", 64'({bus.error, bus.current_state_out}), 64'({1'b0, 3'd3}));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("stall_abort", 64'({bus.aborted, bus.current_state_out}), 64'({1'b1, 3'd0}));
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
